count_clusters_pipe: RTL and testbench
======================================

COUNT_CLUSTERS_PIPE -- requirements
Module: count_clusters_pipe

Interface
REQ-001 SHALL have parameter NVPF, default 768, meaning the number of valid-pattern-flag inputs; legal values are multiples of GROUP.
REQ-002 SHALL have parameter GROUP, default 6, meaning the number of flags summed by each leaf popcount.
REQ-003 SHALL have parameter CNTW, default 11, meaning the count output width; legal values satisfy 2^CNTW > NVPF.
REQ-004 SHALL have parameter OVFW, default 16, meaning the width of the overflow event counter.
REQ-005 SHALL have port clock, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port vpfs_i, input, NVPF bits: valid-pattern flags for one bunch crossing.
REQ-008 SHALL have port valid_i, input, 1 bit: qualifies vpfs_i in the current cycle.
REQ-009 SHALL have port thresh_i, input, CNTW bits: overflow threshold, sampled together with vpfs_i.
REQ-010 SHALL have port clear_i, input, 1 bit: synchronous clear of the peak and overflow statistics.
REQ-011 SHALL have port cnt_o, output, CNTW bits: number of set flags.
REQ-012 SHALL have port valid_o, output, 1 bit: cnt_o and overflow_o are valid.
REQ-013 SHALL have port overflow_o, output, 1 bit: cnt_o is greater than the threshold.
REQ-014 SHALL have port peak_o, output, CNTW bits: maximum valid count since the last clear.
REQ-015 SHALL have port ovf_cnt_o, output, OVFW bits: number of valid overflow cycles since the last clear (saturating).

Function
REQ-016 SHALL register vpfs_i, valid_i and thresh_i in stage 0, with the vpfs register protected from equivalent-register merging.
REQ-017 SHALL compute a registered popcount of each GROUP-bit slice in stage 1, giving N1 = NVPF/GROUP leaves padded with zero leaves to P = 2^D, where D = ceil(log2(N1)).
REQ-018 SHALL add adjacent pairs over D registered tree levels, with each level's width one bit wider than its inputs and no truncation before the final CNTW result.
REQ-019 SHALL register the final sum together with its overflow flag in one output stage, for a total latency of LAT = D+3 cycles from vpfs_i to cnt_o (LAT = 10 at default parameters).
REQ-020 SHALL delay valid and thresh through a shift pipeline matched to the data path, so that valid_o, cnt_o and overflow_o refer to the same input cycle.
REQ-021 SHALL compute overflow_o as (sum > delayed thresh) AND delayed valid; when valid_o is 0, cnt_o SHALL be 0 and overflow_o SHALL be 0.
REQ-022 SHALL accept a new input every cycle, with no backpressure and no bubbles required.
REQ-023 SHALL, on each cycle where valid_o=1 and cnt_o > peak_o, set peak_o to cnt_o on the next cycle.
REQ-024 SHALL, on each cycle where overflow_o=1, increment ovf_cnt_o by one, holding at 2^OVFW-1 without wrapping.
REQ-025 SHALL act on clear_i on the output-stage values of the same cycle: peak_o becomes cnt_o if valid_o=1, else 0; ovf_cnt_o becomes 1 if overflow_o=1, else 0.
REQ-026 SHALL continue to flush the pipeline when valid_i is deasserted; in-flight inputs still emerge with their own valid bit.
REQ-027 SHALL produce cnt_o = NVPF and no arithmetic wrap when all flags are set.
REQ-028 SHALL produce cnt_o = 0, overflow_o = 0 and valid_o = 1 when thresh_i = 0 and all flags are 0.

Reset
REQ-029 SHALL, on reset_n low, asynchronously clear all pipeline registers, valid bits, cnt_o, overflow_o, valid_o, peak_o and ovf_cnt_o to 0.
REQ-030 SHALL discard any data in flight when reset asserts mid-operation; no valid_o SHALL appear until LAT cycles after the first valid_i following reset release.

Verification
REQ-031 SHALL cover single-pulse latency: one valid cycle with vpfs=all-ones, thresh=8 -> exactly one valid_o pulse 10 cycles later with cnt_o=768 and overflow_o=1.
REQ-032 SHALL cover boundary threshold: 9 and then 8 set bits spread across different groups, thresh=8 -> overflow_o=1 and then 0; cnt_o=9 and then 8 on back-to-back cycles.
REQ-033 SHALL cover streaming: random vpfs and thresh every cycle with valid toggling -> cnt_o equals a reference popcount delayed by 10 with no gaps, and each threshold pairs with its own data.
REQ-034 SHALL cover peak and clear: counts 5, 40, 12, then clear_i on the cycle cnt_o=12 -> peak_o reads 40, then 12; ovf_cnt_o is 2 before the clear and 1 after it (thresh=8).
REQ-035 SHALL cover saturation: OVFW=4 with 20 consecutive overflow cycles -> ovf_cnt_o holds at 15.
REQ-036 SHALL cover reset mid-stream: assert reset_n low with 5 valid inputs in flight -> all outputs are 0 immediately and no stale valid_o appears after release.

Source files
------------

// File: rtl/count_clusters_pipe.sv
// Pipelined popcount of the valid-pattern flags with threshold overflow flag,
// running peak and saturating overflow-event statistics.
module count_clusters_pipe #(
    parameter int unsigned NVPF  = 768,
    parameter int unsigned GROUP = 6,
    parameter int unsigned CNTW  = 11,
    parameter int unsigned OVFW  = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [NVPF-1:0]  vpfs_i,
    input  logic             valid_i,
    input  logic [CNTW-1:0]  thresh_i,
    input  logic             clear_i,
    output logic [CNTW-1:0]  cnt_o,
    output logic             valid_o,
    output logic             overflow_o,
    output logic [CNTW-1:0]  peak_o,
    output logic [OVFW-1:0]  ovf_cnt_o
);

    localparam int unsigned N1 = NVPF / GROUP;
    localparam int unsigned D  = $clog2(N1);
    localparam int unsigned P  = 1 << D;
    localparam int unsigned LW = $clog2(GROUP + 1);
    localparam logic [OVFW-1:0] OVF_MAX = '1;

    function automatic logic [LW-1:0] popcnt(input logic [GROUP-1:0] v);
        logic [LW-1:0] s;
        s = '0;
        for (int unsigned b = 0; b < GROUP; b++) begin
            s = s + LW'(v[b]);
        end
        return s;
    endfunction

    // Stage 0: input capture; flag register kept distinct from any duplicate
    (* keep = "true", dont_merge = "true" *) logic [NVPF-1:0] vpfs_q;
    logic            valid_q;
    logic [CNTW-1:0] thresh_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vpfs_q   <= '0;
            valid_q  <= 1'b0;
            thresh_q <= '0;
        end else begin
            vpfs_q   <= vpfs_i;
            valid_q  <= valid_i;
            thresh_q <= thresh_i;
        end
    end

    // Level 0 holds the leaf popcounts; each later level adds adjacent pairs one bit wider
    for (genvar l = 0; l <= D; l++) begin : g_lvl
        localparam int unsigned W = LW + l;
        localparam int unsigned N = P >> l;
        logic [W-1:0] node [N];

        if (l == 0) begin : g_leaf
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    for (int unsigned i = 0; i < N; i++) begin
                        node[i] <= '0;
                    end
                end else begin
                    for (int unsigned i = 0; i < N1; i++) begin
                        node[i] <= popcnt(vpfs_q[i*GROUP +: GROUP]);
                    end
                    for (int unsigned i = N1; i < N; i++) begin
                        node[i] <= '0;
                    end
                end
            end
        end else begin : g_add
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    for (int unsigned i = 0; i < N; i++) begin
                        node[i] <= '0;
                    end
                end else begin
                    for (int unsigned i = 0; i < N; i++) begin
                        node[i] <= W'(g_lvl[l-1].node[2*i]) + W'(g_lvl[l-1].node[2*i+1]);
                    end
                end
            end
        end
    end

    logic [CNTW-1:0] tree_sum;
    assign tree_sum = CNTW'(g_lvl[D].node[0]);

    // Valid and threshold ride alongside the leaf stage and the D adder levels
    logic            valid_d  [D+1];
    logic [CNTW-1:0] thresh_d [D+1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i <= D; i++) begin
                valid_d[i]  <= 1'b0;
                thresh_d[i] <= '0;
            end
        end else begin
            valid_d[0]  <= valid_q;
            thresh_d[0] <= thresh_q;
            for (int unsigned i = 1; i <= D; i++) begin
                valid_d[i]  <= valid_d[i-1];
                thresh_d[i] <= thresh_d[i-1];
            end
        end
    end

    // Output stage: count and overflow forced to zero for invalid slots
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_o      <= '0;
            overflow_o <= 1'b0;
            valid_o    <= 1'b0;
        end else begin
            cnt_o      <= valid_d[D] ? tree_sum : '0;
            overflow_o <= valid_d[D] && (tree_sum > thresh_d[D]);
            valid_o    <= valid_d[D];
        end
    end

    // Statistics; a clear restarts them from the current output-stage values
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            peak_o    <= '0;
            ovf_cnt_o <= '0;
        end else if (clear_i) begin
            peak_o    <= valid_o ? cnt_o : '0;
            ovf_cnt_o <= overflow_o ? OVFW'(1) : '0;
        end else begin
            if (valid_o && (cnt_o > peak_o)) begin
                peak_o <= cnt_o;
            end
            if (overflow_o && (ovf_cnt_o != OVF_MAX)) begin
                ovf_cnt_o <= ovf_cnt_o + OVFW'(1);
            end
        end
    end

endmodule

// File: tb/tb_count_clusters_pipe.sv
// Directed and randomized bench for count_clusters_pipe against a queue-based
// reference model of the count, overflow, peak and overflow-event statistics.
module tb_count_clusters_pipe;

    localparam int NVPF  = 768;
    localparam int GROUP = 6;
    localparam int CNTW  = 11;
    localparam int OVFW  = 16;
    localparam int LAT   = 10;

    logic              clock;
    logic              reset_n;
    logic [NVPF-1:0]   vpfs;
    logic              valid;
    logic [CNTW-1:0]   thresh;
    logic              clear;

    logic [CNTW-1:0]   cnt_o,  cnt4;
    logic              valid_o, valid4;
    logic              ovf_o,  ovf4;
    logic [CNTW-1:0]   peak_o, peak4;
    logic [OVFW-1:0]   ovfc_o;
    logic [3:0]        ovfc4;

    count_clusters_pipe #(.NVPF(NVPF), .GROUP(GROUP), .CNTW(CNTW), .OVFW(OVFW)) dut (
        .clock(clock), .reset_n(reset_n), .vpfs_i(vpfs), .valid_i(valid),
        .thresh_i(thresh), .clear_i(clear), .cnt_o(cnt_o), .valid_o(valid_o),
        .overflow_o(ovf_o), .peak_o(peak_o), .ovf_cnt_o(ovfc_o)
    );

    count_clusters_pipe #(.NVPF(NVPF), .GROUP(GROUP), .CNTW(CNTW), .OVFW(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .vpfs_i(vpfs), .valid_i(valid),
        .thresh_i(thresh), .clear_i(clear), .cnt_o(cnt4), .valid_o(valid4),
        .overflow_o(ovf4), .peak_o(peak4), .ovf_cnt_o(ovfc4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: input history queue plus expected outputs and statistics
    typedef struct { bit v; int c; int t; } ent_t;
    ent_t q[$];
    bit   m_valid, m_ovf;
    int   m_cnt, m_peak, m_oc, m_oc4;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_valid = 1'b0; m_ovf = 1'b0;
        m_cnt = 0; m_peak = 0; m_oc = 0; m_oc4 = 0;
    endtask

    task automatic model_step();
        ent_t e;
        if (clear) begin
            m_peak = m_valid ? m_cnt : 0;
            m_oc   = m_ovf ? 1 : 0;
            m_oc4  = m_oc;
        end else begin
            if (m_valid && m_cnt > m_peak) m_peak = m_cnt;
            if (m_ovf) begin
                if (m_oc < 65535) m_oc++;
                if (m_oc4 < 15) m_oc4++;
            end
        end
        e.v = valid;
        e.c = $countones(vpfs);
        e.t = int'(thresh);
        q.push_back(e);
        if (q.size() > LAT) void'(q.pop_front());
        if (q.size() == LAT) begin
            m_valid = q[0].v;
            m_cnt   = q[0].v ? q[0].c : 0;
            m_ovf   = q[0].v && (q[0].c > q[0].t);
        end else begin
            m_valid = 1'b0; m_cnt = 0; m_ovf = 1'b0;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".valid"},   32'(valid_o), 32'(m_valid));
        chk({tag, ".cnt"},     32'(cnt_o),   m_cnt);
        chk({tag, ".ovf"},     32'(ovf_o),   32'(m_ovf));
        chk({tag, ".peak"},    32'(peak_o),  m_peak);
        chk({tag, ".ovfcnt"},  32'(ovfc_o),  m_oc);
        chk({tag, ".ovfcnt4"}, 32'(ovfc4),   m_oc4);
    endtask

    // One clock: DUT and model sample at the rising edge, outputs checked at the falling edge
    task automatic step();
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_outputs("model");
    endtask

    task automatic drive(input logic v, input logic [NVPF-1:0] f, input int t);
        valid  = v;
        vpfs   = f;
        thresh = CNTW'(t);
    endtask

    task automatic idle(input int n);
        drive(1'b0, '0, 0);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic clear_stats();
        idle(LAT);
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    function automatic logic [NVPF-1:0] spread(input int n);
        logic [NVPF-1:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[(i * 19) % NVPF] = 1'b1;
        return v;
    endfunction

    initial begin
        int pulses;
        int mode;
        int stale;
        logic [NVPF-1:0] ones;
        ones = '1;

        reset_n = 1'b0;
        clear   = 1'b0;
        drive(1'b0, '0, 0);
        model_reset();
        @(negedge clock);
        @(negedge clock);
        chk("reset.cnt",    32'(cnt_o),   0);
        chk("reset.valid",  32'(valid_o), 0);
        chk("reset.ovf",    32'(ovf_o),   0);
        chk("reset.peak",   32'(peak_o),  0);
        chk("reset.ovfcnt", 32'(ovfc_o),  0);
        reset_n = 1'b1;

        // Single pulse of all-ones with threshold 8
        clear_stats();
        drive(1'b1, ones, 8);
        step();
        drive(1'b0, '0, 0);
        pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (valid_o === 1'b1) begin
                pulses++;
                chk("pulse.latency", 32'(k + 1), 32'(LAT));
                chk("pulse.cnt", 32'(cnt_o), 32'(NVPF));
                chk("pulse.ovf", 32'(ovf_o), 1);
            end
        end
        chk("pulse.count", 32'(pulses), 1);

        // Threshold boundary: 9 then 8 set bits, back to back
        drive(1'b1, spread(9), 8);
        step();
        drive(1'b1, spread(8), 8);
        step();
        idle(LAT - 2);
        chk("bound9.cnt", 32'(cnt_o), 9);
        chk("bound9.ovf", 32'(ovf_o), 1);
        step();
        chk("bound8.cnt", 32'(cnt_o), 8);
        chk("bound8.ovf", 32'(ovf_o), 0);

        // All-zero flags with zero threshold
        drive(1'b1, '0, 0);
        step();
        idle(LAT - 1);
        chk("zero.valid", 32'(valid_o), 1);
        chk("zero.cnt",   32'(cnt_o),   0);
        chk("zero.ovf",   32'(ovf_o),   0);

        // Peak and overflow statistics without clear: 5, 40, 12
        clear_stats();
        drive(1'b1, spread(5), 8);  step();
        drive(1'b1, spread(40), 8); step();
        drive(1'b1, spread(12), 8); step();
        idle(LAT);
        chk("peakA.peak",   32'(peak_o), 40);
        chk("peakA.ovfcnt", 32'(ovfc_o), 2);

        // Same counts, clear asserted in the cycle cnt_o shows 12
        clear_stats();
        drive(1'b1, spread(5), 8);  step();
        drive(1'b1, spread(40), 8); step();
        drive(1'b1, spread(12), 8); step();
        idle(LAT - 1);
        chk("peakB.cnt",  32'(cnt_o),  12);
        chk("peakB.peak", 32'(peak_o), 40);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("peakB.peak_after",   32'(peak_o), 12);
        chk("peakB.ovfcnt_after", 32'(ovfc_o), 1);

        // Twenty consecutive overflow cycles: narrow counter saturates
        clear_stats();
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, ones, 0);
            step();
        end
        idle(LAT + 2);
        chk("sat.ovfcnt4", 32'(ovfc4),  15);
        chk("sat.ovfcnt",  32'(ovfc_o), 20);

        // Random streaming with toggling valid and occasional clears
        for (int n = 0; n < 300; n++) begin
            mode = $urandom_range(0, 3);
            for (int w = 0; w < NVPF / 32; w++) begin
                logic [31:0] r;
                r = $urandom;
                if (mode == 0) r = r & $urandom & $urandom;
                else if (mode == 1) r = r | $urandom;
                else if (mode == 3) r = '1;
                vpfs[w*32 +: 32] = r;
            end
            valid  = 1'($urandom_range(0, 1));
            thresh = CNTW'($urandom_range(0, NVPF));
            clear  = ($urandom_range(0, 15) == 0);
            step();
        end
        clear = 1'b0;
        idle(LAT + 2);

        // Reset with five valid inputs in flight
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, ones, 0);
            step();
        end
        drive(1'b0, '0, 0);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk("midrst.cnt",     32'(cnt_o),   0);
        chk("midrst.valid",   32'(valid_o), 0);
        chk("midrst.ovf",     32'(ovf_o),   0);
        chk("midrst.peak",    32'(peak_o),  0);
        chk("midrst.ovfcnt",  32'(ovfc_o),  0);
        chk("midrst.ovfcnt4", 32'(ovfc4),   0);
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        check_outputs("in_reset");
        reset_n = 1'b1;
        stale = 0;
        for (int k = 0; k < LAT + 5; k++) begin
            step();
            if (valid_o !== 1'b0) stale++;
        end
        chk("midrst.stale_valid", 32'(stale), 0);

        // First input after reset release emerges with normal latency
        drive(1'b1, spread(33), 20);
        step();
        idle(LAT - 1);
        chk("post.valid", 32'(valid_o), 1);
        chk("post.cnt",   32'(cnt_o),   33);
        chk("post.ovf",   32'(ovf_o),   1);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
